// File: rtl/twdl_pkg.sv
// Shared constants, FSM state type and lane typedefs for the twiddle index generator.
package twdl_pkg;

  localparam int N_LANE    = 5;
  localparam int MAX_RADIX = 5;
  localparam int WDATA_DEF = 30;
  localparam int WIDX_DEF  = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_READY = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  typedef logic signed [WDATA_DEF-1:0] lane_t;
  typedef lane_t                       lane_vec_t [N_LANE];

  function automatic logic is_legal_radix(input logic [2:0] r);
    return (r >= 3'd2) && (r <= 3'(MAX_RADIX));
  endfunction

endpackage

// File: rtl/twdl_cfg_div.sv
// Restoring divider L / r: one quotient bit per cycle, done pulses after wIdx cycles.
module twdl_cfg_div #(
  parameter int wIdx = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [wIdx-1:0] dividend_i,
  input  logic [2:0]      divisor_i,
  output logic            done_o,
  output logic [wIdx-1:0] quotient_o,
  output logic            rem_nz_o
);

  localparam int CW = $clog2(wIdx + 1);

  logic            run_q;
  logic            done_q;
  logic [CW-1:0]   cnt_q;
  logic [wIdx-1:0] rem_q;
  logic [wIdx-1:0] quo_q;
  logic [wIdx-1:0] dvs_q;

  // The running remainder stays below the divisor, so its top bit is never shifted out.
  function automatic logic [2*wIdx-1:0] div_step(input logic [wIdx-1:0] rem,
                                                 input logic [wIdx-1:0] quo,
                                                 input logic [wIdx-1:0] dvs);
    logic [wIdx-1:0] trial;
    trial = {rem[wIdx-2:0], quo[wIdx-1]};
    if (trial >= dvs) return {trial - dvs, quo[wIdx-2:0], 1'b1};
    else              return {trial, quo[wIdx-2:0], 1'b0};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q  <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        run_q <= 1'b1;
        cnt_q <= CW'(wIdx - 1);
      end else if (run_q) begin
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  // The first quotient bit is resolved on the start edge itself.
  always_ff @(posedge clk) begin
    if (start_i) begin
      dvs_q          <= {{(wIdx-3){1'b0}}, divisor_i};
      {rem_q, quo_q} <= div_step('0, dividend_i, {{(wIdx-3){1'b0}}, divisor_i});
    end else if (run_q) begin
      {rem_q, quo_q} <= div_step(rem_q, quo_q, dvs_q);
    end
  end

  assign done_o     = done_q;
  assign quotient_o = quo_q;
  assign rem_nz_o   = |rem_q;

endmodule

// File: rtl/twdl_idx_gen.sv
// Twiddle numerator/denominator generator ahead of the CTA multiplier, one-cycle latency.
// Optional macro TWDL_IDX_DROP_CNT_EN adds a saturating drop_cnt output.
module twdl_idx_gen
  import twdl_pkg::*;
#(
  parameter int wDataInOut = WDATA_DEF,
  parameter int wIdx       = WIDX_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_load,
  input  logic [2:0]                   cfg_factor,
  input  logic [wIdx-1:0]              cfg_demontr,
  output logic                         cfg_busy,
  output logic                         cfg_err,
  input  logic                         in_val,
  input  logic signed [wDataInOut-1:0] din_real [N_LANE],
  input  logic signed [wDataInOut-1:0] din_imag [N_LANE],
  output logic                         out_val,
  output logic signed [wDataInOut-1:0] dout_real [N_LANE],
  output logic signed [wDataInOut-1:0] dout_imag [N_LANE],
  output logic [2:0]                   factor,
  output logic [wIdx-1:0]              twdl_numrtr [N_LANE],
  output logic [wIdx-1:0]              twdl_demontr,
  output logic                         blk_last,
  output logic                         drop
`ifdef TWDL_IDX_DROP_CNT_EN
 ,output logic [7:0]                   drop_cnt
`endif
);

  state_t state_q, state_d, prev_q, prev_d, post_st;

  logic [2:0]      r_q, pend_r_q;
  logic [wIdx-1:0] l_q, pend_l_q, q_q, m_q;
  logic [wIdx-1:0] acc_q [N_LANE];

  logic            div_start, div_done, div_rem_nz, div_ok, commit;
  logic [wIdx-1:0] div_quo;
  logic            accept, last, cfg_rej;

  logic                         out_val_q, blk_last_q, drop_q, cfg_err_q;
  logic signed [wDataInOut-1:0] dr_q [N_LANE];
  logic signed [wDataInOut-1:0] di_q [N_LANE];
  logic [wIdx-1:0]              num_q [N_LANE];

  assign div_start = cfg_load && (state_q == ST_IDLE || state_q == ST_READY)
                     && is_legal_radix(cfg_factor) && (cfg_demontr != '0);
  assign cfg_rej   = cfg_load && !div_start;
  assign div_ok    = !div_rem_nz && (div_quo != '0);
  assign commit    = div_done && div_ok;
  assign accept    = in_val && (state_q == ST_READY || state_q == ST_RUN);
  assign last      = (m_q == q_q - wIdx'(1));

  twdl_cfg_div #(.wIdx(wIdx)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start_i   (div_start),
    .dividend_i(cfg_demontr),
    .divisor_i (cfg_factor),
    .done_o    (div_done),
    .quotient_o(div_quo),
    .rem_nz_o  (div_rem_nz)
  );

  // A failed division falls back to prev_q, which already includes any vector accepted on the load cycle.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    post_st = state_q;
    if (accept) post_st = last ? ST_READY : ST_RUN;
    case (state_q)
      ST_IDLE: begin
        if (div_start) begin
          state_d = ST_CALC;
          prev_d  = ST_IDLE;
        end
      end
      ST_READY, ST_RUN: begin
        state_d = post_st;
        if (div_start) begin
          state_d = ST_CALC;
          prev_d  = post_st;
        end
      end
      ST_CALC: begin
        if (div_done) state_d = div_ok ? ST_READY : prev_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      prev_q    <= ST_IDLE;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      cfg_err_q <= cfg_rej || (div_done && !div_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (div_start) begin
      pend_r_q <= cfg_factor;
      pend_l_q <= cfg_demontr;
    end
  end

  // Lane accumulators hold i*m for the next accepted vector; lanes at or above r stay zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
      l_q <= '0;
      q_q <= '0;
      m_q <= '0;
      for (int i = 0; i < N_LANE; i++) acc_q[i] <= '0;
    end else if (commit) begin
      r_q <= pend_r_q;
      l_q <= pend_l_q;
      q_q <= div_quo;
      m_q <= '0;
      for (int i = 0; i < N_LANE; i++) acc_q[i] <= '0;
    end else if (accept) begin
      if (last) begin
        m_q <= '0;
        for (int i = 0; i < N_LANE; i++) acc_q[i] <= '0;
      end else begin
        m_q <= m_q + wIdx'(1);
        for (int i = 0; i < N_LANE; i++)
          if (3'(i) < r_q) acc_q[i] <= acc_q[i] + wIdx'(i);
      end
    end
  end

  // Output stage: one register between input vector and output vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_val_q  <= 1'b0;
      blk_last_q <= 1'b0;
      drop_q     <= 1'b0;
      for (int i = 0; i < N_LANE; i++) begin
        dr_q[i]  <= '0;
        di_q[i]  <= '0;
        num_q[i] <= '0;
      end
    end else begin
      out_val_q  <= accept;
      drop_q     <= in_val && !accept;
      blk_last_q <= accept && last;
      for (int i = 0; i < N_LANE; i++) begin
        dr_q[i]  <= accept ? din_real[i] : '0;
        di_q[i]  <= accept ? din_imag[i] : '0;
        num_q[i] <= accept ? acc_q[i] : '0;
      end
    end
  end

`ifdef TWDL_IDX_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    drop_cnt_q <= '0;
    else if (commit)                            drop_cnt_q <= '0;
    else if (in_val && !accept && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign cfg_busy     = (state_q == ST_CALC);
  assign cfg_err      = cfg_err_q;
  assign out_val      = out_val_q;
  assign dout_real    = dr_q;
  assign dout_imag    = di_q;
  assign twdl_numrtr  = num_q;
  assign factor       = r_q;
  assign twdl_demontr = l_q;
  assign blk_last     = blk_last_q;
  assign drop         = drop_q;

endmodule

// File: tb/tb_twdl_idx_gen.sv
// Directed bench for twdl_idx_gen; define TWDL_IDX_DROP_CNT_EN to also cover drop_cnt.
module tb_twdl_idx_gen;
  import twdl_pkg::*;

  localparam int WD = 30;
  localparam int WI = 12;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cfg_load;
  logic [2:0]           cfg_factor;
  logic [WI-1:0]        cfg_demontr;
  logic                 cfg_busy, cfg_err;
  logic                 in_val;
  logic signed [WD-1:0] din_real [5];
  logic signed [WD-1:0] din_imag [5];
  logic                 out_val;
  logic signed [WD-1:0] dout_real [5];
  logic signed [WD-1:0] dout_imag [5];
  logic [2:0]           factor;
  logic [WI-1:0]        twdl_numrtr [5];
  logic [WI-1:0]        twdl_demontr;
  logic                 blk_last, drop;
`ifdef TWDL_IDX_DROP_CNT_EN
  logic [7:0]           drop_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  twdl_idx_gen #(.wDataInOut(WD), .wIdx(WI)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_load    (cfg_load),
    .cfg_factor  (cfg_factor),
    .cfg_demontr (cfg_demontr),
    .cfg_busy    (cfg_busy),
    .cfg_err     (cfg_err),
    .in_val      (in_val),
    .din_real    (din_real),
    .din_imag    (din_imag),
    .out_val     (out_val),
    .dout_real   (dout_real),
    .dout_imag   (dout_imag),
    .factor      (factor),
    .twdl_numrtr (twdl_numrtr),
    .twdl_demontr(twdl_demontr),
    .blk_last    (blk_last),
    .drop        (drop)
`ifdef TWDL_IDX_DROP_CNT_EN
   ,.drop_cnt    (drop_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int base);
    for (int i = 0; i < 5; i++) begin
      din_real[i] = WD'(base * 8 + i);
      din_imag[i] = WD'(-(base * 8 + i));
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, ".out_val"}, out_val, 0);
    chk({tag, ".cfg_busy"}, cfg_busy, 0);
    chk({tag, ".cfg_err"}, cfg_err, 0);
    chk({tag, ".factor"}, factor, 0);
    chk({tag, ".demontr"}, twdl_demontr, 0);
    chk({tag, ".blk_last"}, blk_last, 0);
    chk({tag, ".drop"}, drop, 0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("%s.num%0d", tag, i), twdl_numrtr[i], 0);
      chk($sformatf("%s.re%0d", tag, i), dout_real[i], 0);
    end
  endtask

  // Drives one vector, leaves in_val high, and checks the output one cycle later.
  task automatic send_vec(input string tag, input int base, input int m, input int r,
                          input int L, input bit last);
    in_val = 1'b1;
    set_data(base);
    step();
    chk({tag, ".out_val"}, out_val, 1);
    chk({tag, ".drop"}, drop, 0);
    chk({tag, ".blk_last"}, blk_last, last);
    chk({tag, ".factor"}, factor, r);
    chk({tag, ".demontr"}, twdl_demontr, L);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("%s.num%0d", tag, i), twdl_numrtr[i], (i < r) ? i * m : 0);
      chk($sformatf("%s.re%0d", tag, i), dout_real[i], base * 8 + i);
      chk($sformatf("%s.im%0d", tag, i), dout_imag[i], -(base * 8 + i));
    end
  endtask

  task automatic idle_chk(input string tag);
    in_val = 1'b0;
    set_data(99);
    step();
    chk({tag, ".out_val"}, out_val, 0);
    chk({tag, ".blk_last"}, blk_last, 0);
    chk({tag, ".drop"}, drop, 0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("%s.num%0d", tag, i), twdl_numrtr[i], 0);
      chk($sformatf("%s.re%0d", tag, i), dout_real[i], 0);
    end
  endtask

  task automatic cfg_run(input string tag, input int r, input int L, input bit exp_err);
    int n;
    cfg_load    = 1'b1;
    cfg_factor  = 3'(r);
    cfg_demontr = WI'(L);
    step();
    cfg_load = 1'b0;
    chk({tag, ".busy"}, cfg_busy, 1);
    chk({tag, ".err_early"}, cfg_err, 0);
    n = 0;
    while (cfg_busy && n < 40) begin
      step();
      n++;
    end
    chk({tag, ".calc_cycles"}, n, 12);
    chk({tag, ".cfg_err"}, cfg_err, exp_err);
    step();
    chk({tag, ".err_pulse"}, cfg_err, 0);
  endtask

  task automatic reject_chk(input string tag, input int r, input int L, input int act_r,
                            input int act_L);
    cfg_load    = 1'b1;
    cfg_factor  = 3'(r);
    cfg_demontr = WI'(L);
    step();
    cfg_load = 1'b0;
    chk({tag, ".cfg_err"}, cfg_err, 1);
    chk({tag, ".busy"}, cfg_busy, 0);
    chk({tag, ".factor"}, factor, act_r);
    chk({tag, ".demontr"}, twdl_demontr, act_L);
  endtask

  task automatic drop_chk(input string tag);
    in_val = 1'b1;
    set_data(7);
    step();
    in_val = 1'b0;
    chk({tag, ".drop"}, drop, 1);
    chk({tag, ".out_val"}, out_val, 0);
    chk({tag, ".num1"}, twdl_numrtr[1], 0);
  endtask

  initial begin
    rst = 1'b1;
    cfg_load = 1'b0;
    cfg_factor = '0;
    cfg_demontr = '0;
    in_val = 1'b0;
    set_data(0);
    step();
    step();
    rst_chk("reset");
    rst = 1'b0;
    step();

    // Immediate rejects from IDLE, then a discarded vector
    reject_chk("rej_r6", 6, 20, 0, 0);
    step();
    chk("rej_r6.err_pulse", cfg_err, 0);
    reject_chk("rej_L0", 4, 0, 0, 0);
    step();
    drop_chk("idle_drop");

    // r=4, L=20, Q=5: five back-to-back vectors
    cfg_run("cfg_4_20", 4, 20, 0);
    chk("cfg_4_20.factor", factor, 4);
    chk("cfg_4_20.demontr", twdl_demontr, 20);
    chk("cfg_4_20.out_val_pre", out_val, 0);
    for (int m = 0; m < 5; m++) send_vec($sformatf("g4_m%0d", m), 10 + m, m, 4, 20, m == 4);
    idle_chk("g4_idle");
    chk("g4_idle.factor", factor, 4);
    chk("g4_idle.demontr", twdl_demontr, 20);

    // r=3, L=20 has a remainder: rejected after the divider, stays IDLE
    rst = 1'b1;
    step();
    rst = 1'b0;
    cfg_run("cfg_3_20", 3, 20, 1);
    chk("cfg_3_20.factor", factor, 0);
    chk("cfg_3_20.demontr", twdl_demontr, 0);
    drop_chk("after_bad_cfg");

    // r=5, L=25 with gaps in in_val
    cfg_run("cfg_5_25", 5, 25, 0);
    send_vec("g5_m0", 20, 0, 5, 25, 0);
    idle_chk("g5_gap0");
    send_vec("g5_m1", 21, 1, 5, 25, 0);
    idle_chk("g5_gap1a");
    idle_chk("g5_gap1b");
    send_vec("g5_m2", 22, 2, 5, 25, 0);
    send_vec("g5_m3", 23, 3, 5, 25, 0);
    idle_chk("g5_gap3");
    send_vec("g5_m4", 24, 4, 5, 25, 1);
    send_vec("g5_next_m0", 25, 0, 5, 25, 0);

    // Asynchronous reset mid-RUN, with out_val high
    chk("pre_rst.out_val", out_val, 1);
    in_val = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    rst_chk("rst_run");
    step();
    rst = 1'b0;
    drop_chk("rst_run_drop");

    // r=2, L=8: reconfig attempt inside the group is rejected
    cfg_run("cfg_2_8", 2, 8, 0);
`ifdef TWDL_IDX_DROP_CNT_EN
    chk("cfg_2_8.drop_cnt_clr", drop_cnt, 0);
`endif
    send_vec("g2_m0", 30, 0, 2, 8, 0);
    send_vec("g2_m1", 31, 1, 2, 8, 0);
    idle_chk("g2_idle");
    reject_chk("rej_run", 3, 9, 2, 8);
    send_vec("g2_m2", 32, 2, 2, 8, 0);
    send_vec("g2_m3", 33, 3, 2, 8, 1);
    send_vec("g2_next_m0", 34, 0, 2, 8, 0);
    send_vec("g2_next_m1", 35, 1, 2, 8, 0);
    send_vec("g2_next_m2", 36, 2, 2, 8, 0);
    send_vec("g2_next_m3", 37, 3, 2, 8, 1);
    idle_chk("g2_end");

    // r=3, L=3, Q=1: every vector closes its group
    cfg_run("cfg_3_3", 3, 3, 0);
    for (int k = 0; k < 3; k++) send_vec($sformatf("g1_v%0d", k), 40 + k, 0, 3, 3, 1);
    idle_chk("g1_idle");

    // Asynchronous reset mid-CALC; a vector during CALC is dropped
    cfg_load    = 1'b1;
    cfg_factor  = 3'd4;
    cfg_demontr = 12'd20;
    step();
    cfg_load = 1'b0;
    drop_chk("calc_drop");
    chk("calc.busy", cfg_busy, 1);
    chk("calc.factor_old", factor, 3);
    #2;
    rst = 1'b1;
    #1;
    rst_chk("rst_calc");
    step();
    rst = 1'b0;
    step();
    rst_chk("rst_calc_idle");
    drop_chk("rst_calc_drop");

`ifdef TWDL_IDX_DROP_CNT_EN
    chk("drop_cnt.one", drop_cnt, 1);
    in_val = 1'b1;
    for (int k = 0; k < 300; k++) step();
    in_val = 1'b0;
    chk("drop_cnt.sat", drop_cnt, 255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
